// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: the signal bundle between the two pipeline requesters
// (fetch = port 0, memory stage = port 1), the arbiter, and the system bus.
//   p0/p1 : request, rw (1 = write), address, wdata in; rdata, ready out
//   bus   : request, rw, address, wdata out; rdata, ready in
// Modports:
//   master : arbiter view (it masters the system bus, serves p0/p1)
//   slave  : environment view (requesters plus the bus/cache side)
interface cpu_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_p0_request;
   logic          i_p0_rw;
   logic [AW-1:0] i_p0_address;
   logic [DW-1:0] i_p0_wdata;
   logic [DW-1:0] o_p0_rdata;
   logic          o_p0_ready;

   logic          i_p1_request;
   logic          i_p1_rw;
   logic [AW-1:0] i_p1_address;
   logic [DW-1:0] i_p1_wdata;
   logic [DW-1:0] o_p1_rdata;
   logic          o_p1_ready;

   logic          o_bus_request;
   logic          o_bus_rw;
   logic [AW-1:0] o_bus_address;
   logic [DW-1:0] o_bus_wdata;
   logic [DW-1:0] i_bus_rdata;
   logic          i_bus_ready;

   modport master (
      input  i_p0_request, i_p0_rw, i_p0_address, i_p0_wdata,
      output o_p0_rdata, o_p0_ready,
      input  i_p1_request, i_p1_rw, i_p1_address, i_p1_wdata,
      output o_p1_rdata, o_p1_ready,
      output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
      input  i_bus_rdata, i_bus_ready
   );

   modport slave (
      output i_p0_request, i_p0_rw, i_p0_address, i_p0_wdata,
      input  o_p0_rdata, o_p0_ready,
      output i_p1_request, i_p1_rw, i_p1_address, i_p1_wdata,
      input  o_p1_rdata, o_p1_ready,
      input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
      output i_bus_rdata, i_bus_ready
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one CPU memory bus between fetch (port 0) and the
// memory stage (port 1) with round-robin fairness.
// Ports:
//   i_clock : system clock
//   i_reset : synchronous, active-high reset
//   bus     : cpu_bus_arbiter_if.master (both requester ports + system bus)
// Flow: IDLE (sample requests, latch winner) -> GRANT (hold bus until
// i_bus_ready) -> RELEASE (one-cycle ready pulse, requests not sampled).

// Per-port response register: ready pulse and sticky read data.
module cpu_bus_arbiter_port #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          done,
   input  logic [DW-1:0] bus_rdata,
   output logic          ready,
   output logic [DW-1:0] rdata
);
   always_ff @(posedge clk) begin
      if (rst) begin
         ready <= 1'b0;
         rdata <= '0;
      end else begin
         // done can only be high in GRANT, so ready drops after one cycle
         ready <= done;
         if (done) rdata <= bus_rdata;
      end
   end
endmodule

module cpu_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic               i_clock,
   input logic               i_reset,
   cpu_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t                 state, state_nxt;
   logic                   r_last;     // last port granted
   logic                   gnt;        // port owning the current transaction
   logic                   take;       // grant happens on this edge
   logic                   winner;
   logic                   done;       // bus completed the granted transaction
   logic [1:0]             req;
   logic [1:0]             rw;
   logic [1:0][AW-1:0]     addr;
   logic [1:0][DW-1:0]     wdata;
   logic [1:0]             done_vec;
   logic [1:0]             ready;
   logic [1:0][DW-1:0]     rdata;

   assign req   = {bus.i_p1_request, bus.i_p0_request};
   assign rw    = {bus.i_p1_rw, bus.i_p0_rw};
   assign addr  = {bus.i_p1_address, bus.i_p0_address};
   assign wdata = {bus.i_p1_wdata, bus.i_p0_wdata};

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      winner    = r_last;
      done      = 1'b0;
      case (state)
         IDLE: if (|req) begin
            take      = 1'b1;
            // contention goes to the port that did not win last time
            winner    = (&req) ? ~r_last : req[1];
            state_nxt = GRANT;
         end
         GRANT: if (bus.i_bus_ready) begin
            done      = 1'b1;
            state_nxt = RELEASE;
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state             <= IDLE;
         r_last            <= 1'b0;
         gnt               <= 1'b0;
         bus.o_bus_request <= 1'b0;
         bus.o_bus_rw      <= 1'b0;
         bus.o_bus_address <= '0;
         bus.o_bus_wdata   <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            bus.o_bus_request <= 1'b1;
            bus.o_bus_rw      <= rw[winner];
            bus.o_bus_address <= addr[winner];
            bus.o_bus_wdata   <= wdata[winner];
            r_last            <= winner;
            gnt               <= winner;
         end
         if (done) bus.o_bus_request <= 1'b0;
      end
   end

   assign done_vec = {done & gnt, done & ~gnt};

   for (genvar g = 0; g < 2; g++) begin : g_port
      cpu_bus_arbiter_port #(.DW(DW)) u_port (
         .clk       (i_clock),
         .rst       (i_reset),
         .done      (done_vec[g]),
         .bus_rdata (bus.i_bus_rdata),
         .ready     (ready[g]),
         .rdata     (rdata[g])
      );
   end

   assign bus.o_p0_ready = ready[0];
   assign bus.o_p0_rdata = rdata[0];
   assign bus.o_p1_ready = ready[1];
   assign bus.o_p1_rdata = rdata[1];
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
module tb_cpu_bus_arbiter;
   logic i_clock;
   logic i_reset;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   int   p0_cnt = 0;
   int   p1_cnt = 0;
   logic [31:0] exp_rd0, exp_rd1;

   cpu_bus_arbiter_if #(.AW(32), .DW(32)) bus_if ();

   cpu_bus_arbiter #(.AW(32), .DW(32)) dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (bus_if)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // count ready pulses (one sample per cycle, away from the active edge)
   always @(negedge i_clock) begin
      if (bus_if.o_p0_ready === 1'b1) p0_cnt++;
      if (bus_if.o_p1_ready === 1'b1) p1_cnt++;
   end

   task automatic tick;
      @(posedge i_clock);
      #1;
   endtask

   task automatic bus_complete(input logic [31:0] d, input int dly);
      repeat (dly) tick();
      bus_if.i_bus_rdata = d;
      bus_if.i_bus_ready = 1'b1;
      tick();
      bus_if.i_bus_ready = 1'b0;
   endtask

   task automatic do_reset;
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   task automatic test_reset;
      bus_if.i_p0_request = 0; bus_if.i_p0_rw = 0; bus_if.i_p0_address = 0; bus_if.i_p0_wdata = 0;
      bus_if.i_p1_request = 0; bus_if.i_p1_rw = 0; bus_if.i_p1_address = 0; bus_if.i_p1_wdata = 0;
      bus_if.i_bus_rdata = 0; bus_if.i_bus_ready = 0;
      i_reset = 1'b1;
      tick();
      tick();
      chk_cnt++;
      if ({bus_if.o_bus_request, bus_if.o_bus_rw, bus_if.o_p0_ready, bus_if.o_p1_ready} !== 4'b0)
         $display("FAIL reset_ctrl: got %b want 0000", {bus_if.o_bus_request, bus_if.o_bus_rw, bus_if.o_p0_ready, bus_if.o_p1_ready});
      else pass_cnt++;
      chk_cnt++;
      if ({bus_if.o_bus_address, bus_if.o_bus_wdata, bus_if.o_p0_rdata, bus_if.o_p1_rdata} !== 128'b0)
         $display("FAIL reset_data: got %h want 0", {bus_if.o_bus_address, bus_if.o_bus_wdata, bus_if.o_p0_rdata, bus_if.o_p1_rdata});
      else pass_cnt++;
      i_reset = 1'b0;
      exp_rd0 = 0;
      exp_rd1 = 0;
   endtask

   task automatic test_single_read;
      int c1;
      c1 = p1_cnt;
      bus_if.i_p0_request = 1; bus_if.i_p0_rw = 0; bus_if.i_p0_address = 32'h100;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b1 || bus_if.o_bus_address !== 32'h100 || bus_if.o_bus_rw !== 1'b0)
         $display("FAIL single_grant: req=%b addr=%h rw=%b want 1/100/0", bus_if.o_bus_request, bus_if.o_bus_address, bus_if.o_bus_rw);
      else pass_cnt++;
      bus_complete(32'hDEADBEEF, 2);
      exp_rd0 = 32'hDEADBEEF;
      chk_cnt++;
      if (bus_if.o_p0_ready !== 1'b1 || bus_if.o_p0_rdata !== exp_rd0 || bus_if.o_bus_request !== 1'b0)
         $display("FAIL single_ready: rdy=%b rdata=%h busreq=%b want 1/%h/0", bus_if.o_p0_ready, bus_if.o_p0_rdata, bus_if.o_bus_request, exp_rd0);
      else pass_cnt++;
      bus_if.i_p0_request = 0;
      tick();
      chk_cnt++;
      if (bus_if.o_p0_ready !== 1'b0 || bus_if.o_p0_rdata !== exp_rd0)
         $display("FAIL single_after: rdy=%b rdata=%h want 0/%h", bus_if.o_p0_ready, bus_if.o_p0_rdata, exp_rd0);
      else pass_cnt++;
      chk_cnt++;
      if (p1_cnt != c1 || bus_if.o_p1_rdata !== 32'h0)
         $display("FAIL single_p1_quiet: p1 pulses=%0d rdata=%h want 0/0", p1_cnt - c1, bus_if.o_p1_rdata);
      else pass_cnt++;
   endtask

   task automatic test_round_robin;
      logic w;
      logic [31:0] d;
      do_reset();
      bus_if.i_p0_request = 1; bus_if.i_p0_rw = 0; bus_if.i_p0_address = 32'h200;
      bus_if.i_p1_request = 1; bus_if.i_p1_rw = 1; bus_if.i_p1_address = 32'h300; bus_if.i_p1_wdata = 32'h12345678;
      exp_rd0 = 0;
      exp_rd1 = 0;
      for (int k = 0; k < 8; k++) begin
         w = (k % 2 == 0);
         d = 32'hC0DE0000 + k;
         tick();
         chk_cnt++;
         if (bus_if.o_bus_request !== 1'b1 || bus_if.o_bus_address !== (w ? 32'h300 : 32'h200) || bus_if.o_bus_rw !== w)
            $display("FAIL rr_grant k=%0d: req=%b addr=%h rw=%b want winner p%0d", k, bus_if.o_bus_request, bus_if.o_bus_address, bus_if.o_bus_rw, w);
         else pass_cnt++;
         if (k == 0) begin
            chk_cnt++;
            if (bus_if.o_bus_wdata !== 32'h12345678)
               $display("FAIL rr_first_wdata: got %h want 12345678", bus_if.o_bus_wdata);
            else pass_cnt++;
         end
         bus_complete(d, k % 3);
         if (w) exp_rd1 = d; else exp_rd0 = d;
         chk_cnt++;
         if (bus_if.o_p1_ready !== w || bus_if.o_p0_ready !== !w || bus_if.o_p0_rdata !== exp_rd0 || bus_if.o_p1_rdata !== exp_rd1)
            $display("FAIL rr_ready k=%0d: rdy1=%b rdy0=%b rd0=%h rd1=%h want %b/%b/%h/%h", k, bus_if.o_p1_ready, bus_if.o_p0_ready, bus_if.o_p0_rdata, bus_if.o_p1_rdata, w, !w, exp_rd0, exp_rd1);
         else pass_cnt++;
         if (k == 7) begin
            bus_if.i_p0_request = 0;
            bus_if.i_p1_request = 0;
         end
         tick();
      end
   endtask

   task automatic test_hold_through_release;
      int c1;
      bus_if.i_p1_request = 1; bus_if.i_p1_rw = 0; bus_if.i_p1_address = 32'h600;
      c1 = p1_cnt;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b1 || bus_if.o_bus_address !== 32'h600)
         $display("FAIL hold_grant: req=%b addr=%h want 1/600", bus_if.o_bus_request, bus_if.o_bus_address);
      else pass_cnt++;
      bus_complete(32'h600D0001, 1);
      exp_rd1 = 32'h600D0001;
      tick();  // request still high through RELEASE
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b0)
         $display("FAIL hold_no_regrant: bus_request=%b want 0", bus_if.o_bus_request);
      else pass_cnt++;
      bus_if.i_p1_request = 0;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b0 || p1_cnt - c1 != 1)
         $display("FAIL hold_single_pulse: bus_request=%b pulses=%0d want 0/1", bus_if.o_bus_request, p1_cnt - c1);
      else pass_cnt++;
   endtask

   task automatic test_ignored_ready;
      int c0, c1, unstable;
      c0 = p0_cnt;
      c1 = p1_cnt;
      unstable = 0;
      bus_if.i_bus_rdata = 32'hBAD0BAD0;
      bus_if.i_bus_ready = 1;
      tick();
      bus_if.i_bus_ready = 0;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b0 || p0_cnt != c0 || p1_cnt != c1 || bus_if.o_p0_rdata !== exp_rd0 || bus_if.o_p1_rdata !== exp_rd1)
         $display("FAIL idle_ready_ignored: busreq=%b rd0=%h rd1=%h want 0/%h/%h", bus_if.o_bus_request, bus_if.o_p0_rdata, bus_if.o_p1_rdata, exp_rd0, exp_rd1);
      else pass_cnt++;
      bus_if.i_p0_request = 1; bus_if.i_p0_rw = 1; bus_if.i_p0_address = 32'h400; bus_if.i_p0_wdata = 32'h55AA55AA;
      for (int i = 0; i < 21; i++) begin
         tick();
         if (bus_if.o_bus_request !== 1'b1 || bus_if.o_bus_rw !== 1'b1 || bus_if.o_bus_address !== 32'h400 || bus_if.o_bus_wdata !== 32'h55AA55AA)
            unstable++;
      end
      chk_cnt++;
      if (unstable != 0 || p0_cnt != c0 || p1_cnt != c1)
         $display("FAIL grant_wait_stable: unstable cycles=%0d stray pulses=%0d want 0/0", unstable, (p0_cnt - c0) + (p1_cnt - c1));
      else pass_cnt++;
      bus_complete(32'h77770000, 0);
      exp_rd0 = 32'h77770000;
      chk_cnt++;
      if (bus_if.o_p0_ready !== 1'b1 || bus_if.o_p1_ready !== 1'b0 || bus_if.o_p0_rdata !== exp_rd0 || bus_if.o_p1_rdata !== exp_rd1)
         $display("FAIL long_wait_done: rdy0=%b rdy1=%b rd0=%h rd1=%h want 1/0/%h/%h", bus_if.o_p0_ready, bus_if.o_p1_ready, bus_if.o_p0_rdata, bus_if.o_p1_rdata, exp_rd0, exp_rd1);
      else pass_cnt++;
      bus_if.i_p0_request = 0;
      tick();
   endtask

   task automatic test_reset_mid;
      int c0, c1;
      c0 = p0_cnt;
      c1 = p1_cnt;
      // p1 is granted so that r_last would favour p0 without reset
      bus_if.i_p1_request = 1; bus_if.i_p1_rw = 1; bus_if.i_p1_address = 32'h700; bus_if.i_p1_wdata = 32'hA5A5A5A5;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b1 || bus_if.o_bus_address !== 32'h700)
         $display("FAIL mid_grant: req=%b addr=%h want 1/700", bus_if.o_bus_request, bus_if.o_bus_address);
      else pass_cnt++;
      i_reset = 1'b1;
      bus_if.i_p1_request = 0;
      tick();
      i_reset = 1'b0;
      chk_cnt++;
      if (bus_if.o_bus_request !== 1'b0 || bus_if.o_p0_ready !== 1'b0 || bus_if.o_p1_ready !== 1'b0)
         $display("FAIL mid_reset_drop: busreq=%b rdy0=%b rdy1=%b want 0/0/0", bus_if.o_bus_request, bus_if.o_p0_ready, bus_if.o_p1_ready);
      else pass_cnt++;
      bus_if.i_bus_rdata = 32'hFEEDFACE;
      bus_if.i_bus_ready = 1;
      tick();
      bus_if.i_bus_ready = 0;
      tick();
      chk_cnt++;
      if (p0_cnt != c0 || p1_cnt != c1 || {bus_if.o_bus_request, bus_if.o_bus_rw, bus_if.o_bus_address, bus_if.o_bus_wdata, bus_if.o_p0_rdata, bus_if.o_p1_rdata} !== 130'b0)
         $display("FAIL mid_late_ready: pulses=%0d busreq=%b rd0=%h rd1=%h want 0/0/0/0", (p0_cnt - c0) + (p1_cnt - c1), bus_if.o_bus_request, bus_if.o_p0_rdata, bus_if.o_p1_rdata);
      else pass_cnt++;
      bus_if.i_p0_request = 1; bus_if.i_p0_rw = 0; bus_if.i_p0_address = 32'h800;
      bus_if.i_p1_request = 1;
      tick();
      chk_cnt++;
      if (bus_if.o_bus_address !== 32'h700 || bus_if.o_bus_rw !== 1'b1 || bus_if.o_bus_wdata !== 32'hA5A5A5A5)
         $display("FAIL mid_next_contention: addr=%h rw=%b wdata=%h want 700/1/a5a5a5a5", bus_if.o_bus_address, bus_if.o_bus_rw, bus_if.o_bus_wdata);
      else pass_cnt++;
      bus_complete(32'h11112222, 0);
      chk_cnt++;
      if (bus_if.o_p1_ready !== 1'b1 || bus_if.o_p1_rdata !== 32'h11112222 || bus_if.o_p0_rdata !== 32'h0)
         $display("FAIL mid_after_done: rdy1=%b rd1=%h rd0=%h want 1/11112222/0", bus_if.o_p1_ready, bus_if.o_p1_rdata, bus_if.o_p0_rdata);
      else pass_cnt++;
      bus_if.i_p0_request = 0;
      bus_if.i_p1_request = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_hold_through_release();
      test_ignored_ready();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Two-port arbiter that shares one CPU memory bus between the fetch stage (port 0) and the memory stage (port 1).
- Fairness is round-robin.
- Each port uses a request/ready handshake. A requester holds its request and transaction fields stable until it sees ready, the same discipline the pipeline skid buffers use.
- Sits between the pipeline stages and the system bus/cache interface.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_p0_request  in  1  port 0 (fetch) transaction request
- i_p0_rw  in  1  port 0 direction: 1 = write, 0 = read
- i_p0_address  in  AW  port 0 address
- i_p0_wdata  in  DW  port 0 write data
- o_p0_rdata  out  DW  port 0 read data, valid while o_p0_ready = 1
- o_p0_ready  out  1  port 0 completion pulse
- i_p1_request, i_p1_rw, i_p1_address, i_p1_wdata, o_p1_rdata, o_p1_ready  as port 0, for port 1 (memory stage)
- o_bus_request  out  1  bus transaction request
- o_bus_rw  out  1  bus direction
- o_bus_address  out  AW  bus address
- o_bus_wdata  out  DW  bus write data
- i_bus_rdata  in  DW  bus read data, valid with i_bus_ready
- i_bus_ready  in  1  bus completion, single-cycle pulse

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the posedge of i_clock.
  - Reset is synchronous, active-high; it has priority over every other event.
- Reset values:
  - state = IDLE.
  - All o_* outputs = 0.
  - Round-robin pointer r_last = 0, so port 1 wins the first contention after reset.
- State IDLE:
  - No request pending: stay in IDLE.
  - Exactly one request pending: grant that port.
  - Both pending: grant the port not equal to r_last.
  - On a grant, in the same edge: latch rw/address/wdata from the winner into the bus output registers, set o_bus_request = 1, set r_last = winner, go to GRANT.
  - Bus request is therefore visible 1 cycle after the request is sampled.
- State GRANT:
  - o_bus_request and the bus fields are held stable.
  - The loser's request is ignored; it stays pending.
  - On i_bus_ready = 1: o_bus_request -> 0; o_pN_ready -> 1 for the granted port only; o_pN_rdata <- i_bus_rdata (captured for writes as well, don't-care to requester); go to RELEASE.
- State RELEASE (exactly 1 cycle):
  - o_pN_ready is high this cycle only; it clears on the next edge.
  - The requester drops its request during this cycle.
  - The arbiter does not sample requests here, so a request still high here is not double-served.
  - Next state is IDLE.
- Throughput and latency:
  - Minimum turnaround from request sampled to ready is 2 cycles + bus latency.
  - Back-to-back grants to the same port are spaced at least 3 cycles apart.
- rdata hold:
  - o_pN_rdata holds its last value after ready drops; it is not cleared.
  - The non-granted port's rdata is never modified.
- Ignored inputs:
  - i_bus_ready in IDLE or RELEASE is ignored: no ready pulse, no state change.
- Reset mid-transaction:
  - In GRANT, reset drops o_bus_request on the next edge and abandons the transaction.
  - No ready pulse is issued to either port.
  - A late i_bus_ready after reset is ignored.
- Requester rules:
  - Dropping a request while granted is illegal.
  - The arbiter keeps the latched fields and completes the transaction regardless.
- Fairness:
  - With both ports continuously requesting, grants alternate 1,0,1,0…
  - No port waits for more than one foreign transaction.

Test Plan:
- Reset, then p0 alone reads 0x100, bus returns 0xDEADBEEF after 3 cycles -> o_bus_request high 1 cycle after request; o_p0_ready pulses 1 cycle with o_p0_rdata = 0xDEADBEEF; o_p1_ready never asserts.
- Both ports request simultaneously after reset (p0 read 0x200, p1 write 0x300 with data 0x12345678) -> p1 served first (bus rw = 1, address 0x300, wdata 0x12345678); p0 served next; grants continue alternating 1,0,1,0 over 8 transactions.
- p1 keeps its request high through RELEASE for one extra cycle -> no second bus transaction is started for that cycle; exactly one o_p1_ready pulse per transaction.
- i_bus_ready pulsed while IDLE, and i_bus_ready held 0 for 20 cycles in GRANT -> no ready pulses and no state change while IDLE; o_bus_request and fields stay stable throughout the 20-cycle wait.
- i_reset asserted in GRANT, then i_bus_ready pulsed 1 cycle later -> o_bus_request = 0 after the edge; no o_p*_ready; all outputs 0; next contention is won by p1.
